// File: rtl/clock_ctrl.sv
// Alarm-clock control block: timebase tick extraction, operating mode,
// time/alarm advance strobes with auto-repeat, and the alarm/buzz/snooze FSM.
//
// Mode FSM
//   state     | meaning
//   MODE_RUN  | time runs, advance buttons ignored
//   MODE_TSET | time frozen, buttons advance time minutes/hours
//   MODE_ASET | time runs, buttons advance alarm minutes/hours, alarm shown
//
// Alarm FSM
//   state    | meaning
//   AL_IDLE  | armed, waiting for a tick while the time matches the alarm
//   AL_BUZZ  | buzzer on, counting ticks to auto-silence
//   AL_SNZ   | snoozing, counting ticks to re-buzz
//   AL_QUIET | silenced, waiting for the matching minute to end
module clock_ctrl #(
    parameter int unsigned BUZZ_SEC = 60,
    parameter int unsigned SNZ_SEC  = 300,
    parameter int unsigned RPT      = 1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Pulse,
    input  logic Timeset,
    input  logic Alarmset,
    input  logic Minadv,
    input  logic Hrsadv,
    input  logic Alarmon,
    input  logic Snooze,
    input  logic Alarm_match,
    output logic Sec_en,
    output logic Min_inc,
    output logic Hrs_inc,
    output logic Amin_inc,
    output logic Ahrs_inc,
    output logic Disp_alarm,
    output logic Buzz
);

    typedef enum logic [1:0] {MODE_RUN, MODE_TSET, MODE_ASET} mode_t;
    typedef enum logic [1:0] {AL_IDLE, AL_BUZZ, AL_SNZ, AL_QUIET} alarm_t;

    localparam logic [8:0] BUZZ_LAST = 9'(BUZZ_SEC) - 9'd1;
    localparam logic [8:0] SNZ_LAST  = 9'(SNZ_SEC) - 9'd1;
    localparam logic [3:0] RPT_LAST  = 4'(RPT) - 4'd1;

    logic   pulse_s1, pulse_s2, pulse_s3, tick;
    logic   min_prev, hrs_prev, snz_prev, match_prev;
    mode_t  mode_q, mode_last, mode_next;
    alarm_t al_q, al_next;
    logic [8:0] al_cnt, al_cnt_next;
    logic [3:0] min_cnt, hrs_cnt;

    logic min_rise, hrs_rise, snz_rise, match_fall;
    logic adv_mode, mode_chg, min_fire, hrs_fire, kill;

    // Pulse synchronizer and registered rising-edge detect (tick 3 Clk after the edge)
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pulse_s1 <= 1'b0;
            pulse_s2 <= 1'b0;
            pulse_s3 <= 1'b0;
            tick     <= 1'b0;
        end else begin
            pulse_s1 <= Pulse;
            pulse_s2 <= pulse_s1;
            pulse_s3 <= pulse_s2;
            tick     <= pulse_s2 & ~pulse_s3;
        end
    end

    // Previous-cycle copies of buttons and match for edge detection
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            min_prev   <= 1'b0;
            hrs_prev   <= 1'b0;
            snz_prev   <= 1'b0;
            match_prev <= 1'b0;
        end else begin
            min_prev   <= Minadv;
            hrs_prev   <= Hrsadv;
            snz_prev   <= Snooze;
            match_prev <= Alarm_match;
        end
    end

    assign min_rise   = Minadv & ~min_prev;
    assign hrs_rise   = Hrsadv & ~hrs_prev;
    assign snz_rise   = Snooze & ~snz_prev;
    assign match_fall = ~Alarm_match & match_prev;

    // Mode next-state: Timeset has priority over Alarmset
    always_comb begin
        mode_next = MODE_RUN;
        if (Timeset)
            mode_next = MODE_TSET;
        else if (Alarmset)
            mode_next = MODE_ASET;
    end

    // Mode register, plus last-cycle mode to detect entry
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mode_q    <= MODE_RUN;
            mode_last <= MODE_RUN;
        end else begin
            mode_q    <= mode_next;
            mode_last <= mode_q;
        end
    end

    assign adv_mode = (mode_q != MODE_RUN);
    assign mode_chg = (mode_q != mode_last);

    // A button held across mode entry is treated like a fresh press.
    assign min_fire = adv_mode & Minadv & (mode_chg | min_rise | (tick & (min_cnt == RPT_LAST)));
    assign hrs_fire = adv_mode & Hrsadv & (mode_chg | hrs_rise | (tick & (hrs_cnt == RPT_LAST)));

    // Auto-repeat counters, one per advance button
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            min_cnt <= 4'd0;
            hrs_cnt <= 4'd0;
        end else begin
            if (!adv_mode || !Minadv || mode_chg || min_rise)
                min_cnt <= 4'd0;
            else if (tick)
                min_cnt <= (min_cnt == RPT_LAST) ? 4'd0 : min_cnt + 4'd1;

            if (!adv_mode || !Hrsadv || mode_chg || hrs_rise)
                hrs_cnt <= 4'd0;
            else if (tick)
                hrs_cnt <= (hrs_cnt == RPT_LAST) ? 4'd0 : hrs_cnt + 4'd1;
        end
    end

    assign Sec_en     = tick & (mode_q != MODE_TSET);
    assign Min_inc    = min_fire & (mode_q == MODE_TSET);
    assign Hrs_inc    = hrs_fire & (mode_q == MODE_TSET);
    assign Amin_inc   = min_fire & (mode_q == MODE_ASET);
    assign Ahrs_inc   = hrs_fire & (mode_q == MODE_ASET);
    assign Disp_alarm = (mode_q == MODE_ASET);

    assign kill = ~Alarmon | (mode_q != MODE_RUN);

    // Alarm next-state and shared tick counter; disable/mode-exit overrides everything
    always_comb begin
        al_next     = al_q;
        al_cnt_next = al_cnt;
        if (kill) begin
            al_next     = AL_IDLE;
            al_cnt_next = 9'd0;
        end else begin
            case (al_q)
                AL_IDLE: begin
                    if (tick && Alarm_match) begin
                        al_next     = AL_BUZZ;
                        al_cnt_next = 9'd0;
                    end
                end
                AL_BUZZ: begin
                    if (snz_rise) begin
                        al_next     = AL_SNZ;
                        al_cnt_next = 9'd0;
                    end else if (tick) begin
                        if (al_cnt == BUZZ_LAST) begin
                            al_next     = AL_QUIET;
                            al_cnt_next = 9'd0;
                        end else begin
                            al_cnt_next = al_cnt + 9'd1;
                        end
                    end
                end
                AL_SNZ: begin
                    if (tick) begin
                        if (al_cnt == SNZ_LAST) begin
                            al_next     = AL_BUZZ;
                            al_cnt_next = 9'd0;
                        end else begin
                            al_cnt_next = al_cnt + 9'd1;
                        end
                    end
                end
                AL_QUIET: begin
                    if (match_fall)
                        al_next = AL_IDLE;
                end
                default: begin
                    al_next     = AL_IDLE;
                    al_cnt_next = 9'd0;
                end
            endcase
        end
    end

    // Alarm state and counter registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            al_q   <= AL_IDLE;
            al_cnt <= 9'd0;
        end else begin
            al_q   <= al_next;
            al_cnt <= al_cnt_next;
        end
    end

    assign Buzz = (al_q == AL_BUZZ) & ~kill;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with BUZZ_SEC=4, SNZ_SEC=3, RPT=1.
// Inputs change 1 time unit after a rising Clk edge; outputs are sampled
// 4 units after the edge, strobes are tallied on the falling edge.
module tb_clock_ctrl;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic Pulse = 1'b0, Timeset = 1'b0, Alarmset = 1'b0, Minadv = 1'b0, Hrsadv = 1'b0;
    logic Alarmon = 1'b0, Snooze = 1'b0, Alarm_match = 1'b0;
    logic Sec_en, Min_inc, Hrs_inc, Amin_inc, Ahrs_inc, Disp_alarm, Buzz;

    int n_cmp = 0;
    int n_err = 0;
    int n_sec, n_min, n_hrs, n_amin, n_ahrs, n_buzz;

    always #5 Clk = ~Clk;

    clock_ctrl #(.BUZZ_SEC(4), .SNZ_SEC(3), .RPT(1)) dut (
        .Clk(Clk), .Reset(Reset), .Pulse(Pulse), .Timeset(Timeset), .Alarmset(Alarmset),
        .Minadv(Minadv), .Hrsadv(Hrsadv), .Alarmon(Alarmon), .Snooze(Snooze),
        .Alarm_match(Alarm_match), .Sec_en(Sec_en), .Min_inc(Min_inc), .Hrs_inc(Hrs_inc),
        .Amin_inc(Amin_inc), .Ahrs_inc(Ahrs_inc), .Disp_alarm(Disp_alarm), .Buzz(Buzz)
    );

    always @(negedge Clk) begin
        if (Reset) begin
            n_sec  += int'(Sec_en);
            n_min  += int'(Min_inc);
            n_hrs  += int'(Hrs_inc);
            n_amin += int'(Amin_inc);
            n_ahrs += int'(Ahrs_inc);
            n_buzz += int'(Buzz);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        n_sec = 0; n_min = 0; n_hrs = 0; n_amin = 0; n_ahrs = 0; n_buzz = 0;
    endtask

    // One Pulse period; the tick lands on the 3rd edge after Pulse rises.
    task automatic pulse_tick();
        Pulse = 1'b1;
        cyc(4);
        Pulse = 1'b0;
        cyc(4);
    endtask

    task automatic test_reset();
        Alarmset = 1'b1; Minadv = 1'b1; Alarmon = 1'b1; Alarm_match = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Pulse = ~Pulse;
            cyc(1);
            #3;
            n_cmp++;
            if ({Sec_en, Min_inc, Hrs_inc, Amin_inc, Ahrs_inc, Disp_alarm, Buzz} !== 7'b0) begin
                n_err++;
                $display("FAIL reset_outputs cycle %0d: got %b want 0000000", i,
                         {Sec_en, Min_inc, Hrs_inc, Amin_inc, Ahrs_inc, Disp_alarm, Buzz});
            end
        end
        Alarmset = 1'b0; Minadv = 1'b0; Alarmon = 1'b0; Alarm_match = 1'b0; Pulse = 1'b0;
        cyc(1);
        Reset = 1'b1;
        clear_counts();
        cyc(4);
        n_cmp++;
        if (n_sec !== 0) begin
            n_err++;
            $display("FAIL reset_no_tick: got %0d want 0", n_sec);
        end
        Pulse = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            #3;
            n_cmp++;
            if (Sec_en !== (i == 3)) begin
                n_err++;
                $display("FAIL tick_latency edge %0d: got %b want %b", i, Sec_en, (i == 3));
            end
        end
        Pulse = 1'b0;
        cyc(4);
        clear_counts();
        repeat (3) pulse_tick();
        n_cmp++;
        if (n_sec !== 3) begin
            n_err++;
            $display("FAIL sec_en_per_pulse: got %0d want 3", n_sec);
        end
    endtask

    task automatic test_time_set();
        Timeset = 1'b1;
        cyc(3);
        clear_counts();
        Minadv = 1'b1;
        #3;
        n_cmp++;
        if (Min_inc !== 1'b1) begin
            n_err++;
            $display("FAIL min_press_strobe: got %b want 1", Min_inc);
        end
        cyc(1);
        repeat (50) pulse_tick();
        Minadv = 1'b0;
        cyc(2);
        n_cmp++;
        if (n_min !== 51 || n_sec !== 0 || n_amin !== 0) begin
            n_err++;
            $display("FAIL tset_repeat: got min=%0d sec=%0d amin=%0d want 51/0/0", n_min, n_sec, n_amin);
        end
        Timeset = 1'b0;
        cyc(3);
        clear_counts();
        Minadv = 1'b1;
        cyc(3);
        n_cmp++;
        if (n_min !== 0) begin
            n_err++;
            $display("FAIL run_ignores_adv: got %0d want 0", n_min);
        end
        Timeset = 1'b1;
        cyc(4);
        n_cmp++;
        if (n_min !== 1) begin
            n_err++;
            $display("FAIL held_on_entry: got %0d want 1", n_min);
        end
        Minadv = 1'b0;
        Timeset = 1'b0;
        cyc(3);
    endtask

    task automatic test_mode_priority();
        Timeset = 1'b1; Alarmset = 1'b1;
        cyc(3);
        clear_counts();
        Hrsadv = 1'b1;
        cyc(1);
        Hrsadv = 1'b0;
        cyc(3);
        n_cmp++;
        if (n_hrs !== 1 || n_ahrs !== 0 || Disp_alarm !== 1'b0) begin
            n_err++;
            $display("FAIL tset_priority: got hrs=%0d ahrs=%0d disp=%b want 1/0/0", n_hrs, n_ahrs, Disp_alarm);
        end
        Timeset = 1'b0;
        #3;
        n_cmp++;
        if (Disp_alarm !== 1'b0) begin
            n_err++;
            $display("FAIL disp_before_edge: got %b want 0", Disp_alarm);
        end
        cyc(1);
        #3;
        n_cmp++;
        if (Disp_alarm !== 1'b1) begin
            n_err++;
            $display("FAIL disp_after_edge: got %b want 1", Disp_alarm);
        end
        cyc(2);
        clear_counts();
        Minadv = 1'b1; Hrsadv = 1'b1;
        #3;
        n_cmp++;
        if (Amin_inc !== 1'b1 || Ahrs_inc !== 1'b1 || Min_inc !== 1'b0) begin
            n_err++;
            $display("FAIL aset_both: got amin=%b ahrs=%b min=%b want 1/1/0", Amin_inc, Ahrs_inc, Min_inc);
        end
        cyc(1);
        pulse_tick();
        Minadv = 1'b0; Hrsadv = 1'b0;
        cyc(2);
        n_cmp++;
        if (n_amin !== 2 || n_ahrs !== 2 || n_sec !== 1 || n_min !== 0) begin
            n_err++;
            $display("FAIL aset_repeat: got amin=%0d ahrs=%0d sec=%0d min=%0d want 2/2/1/0",
                     n_amin, n_ahrs, n_sec, n_min);
        end
        Alarmset = 1'b0;
        cyc(2);
        #3;
        n_cmp++;
        if (Disp_alarm !== 1'b0) begin
            n_err++;
            $display("FAIL disp_run: got %b want 0", Disp_alarm);
        end
        cyc(1);
    endtask

    task automatic test_alarm_buzz();
        Alarmon = 1'b1; Alarm_match = 1'b1;
        cyc(3);
        #3;
        n_cmp++;
        if (Buzz !== 1'b0) begin
            n_err++;
            $display("FAIL buzz_needs_tick: got %b want 0", Buzz);
        end
        Pulse = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            #3;
            n_cmp++;
            if (Buzz !== (i == 4)) begin
                n_err++;
                $display("FAIL buzz_trigger edge %0d: got %b want %b", i, Buzz, (i == 4));
            end
        end
        Pulse = 1'b0;
        cyc(4);
        repeat (3) pulse_tick();
        #3;
        n_cmp++;
        if (Buzz !== 1'b1) begin
            n_err++;
            $display("FAIL buzz_hold_3ticks: got %b want 1", Buzz);
        end
        Pulse = 1'b1;
        cyc(3);
        #3;
        n_cmp++;
        if (Buzz !== 1'b1) begin
            n_err++;
            $display("FAIL buzz_before_4th: got %b want 1", Buzz);
        end
        cyc(1);
        #3;
        n_cmp++;
        if (Buzz !== 1'b0) begin
            n_err++;
            $display("FAIL buzz_timeout: got %b want 0", Buzz);
        end
        Pulse = 1'b0;
        cyc(4);
        clear_counts();
        repeat (2) pulse_tick();
        n_cmp++;
        if (n_buzz !== 0) begin
            n_err++;
            $display("FAIL quiet_no_retrigger: got %0d buzz cycles want 0", n_buzz);
        end
        Alarm_match = 1'b0;
        cyc(2);
        Alarm_match = 1'b1;
        cyc(1);
        pulse_tick();
        #3;
        n_cmp++;
        if (Buzz !== 1'b1) begin
            n_err++;
            $display("FAIL rearm_after_fall: got %b want 1", Buzz);
        end
    endtask

    task automatic test_snooze();
        Snooze = 1'b1;
        #3;
        n_cmp++;
        if (Buzz !== 1'b1) begin
            n_err++;
            $display("FAIL snooze_same_cycle: got %b want 1", Buzz);
        end
        cyc(1);
        #3;
        n_cmp++;
        if (Buzz !== 1'b0) begin
            n_err++;
            $display("FAIL snooze_next_cycle: got %b want 0", Buzz);
        end
        Snooze = 1'b0;
        clear_counts();
        repeat (2) pulse_tick();
        Pulse = 1'b1;
        cyc(3);
        #3;
        n_cmp++;
        if (n_buzz !== 0 || Buzz !== 1'b0) begin
            n_err++;
            $display("FAIL snooze_hold: got buzz_cycles=%0d buzz=%b want 0/0", n_buzz, Buzz);
        end
        cyc(1);
        #3;
        n_cmp++;
        if (Buzz !== 1'b1) begin
            n_err++;
            $display("FAIL snooze_rebuzz: got %b want 1", Buzz);
        end
        Pulse = 1'b0;
        cyc(2);
        Alarmon = 1'b0;
        #3;
        n_cmp++;
        if (Buzz !== 1'b0) begin
            n_err++;
            $display("FAIL alarmon_gate: got %b want 0", Buzz);
        end
        cyc(1);
        Alarmon = 1'b1;
        clear_counts();
        cyc(3);
        n_cmp++;
        if (n_buzz !== 0) begin
            n_err++;
            $display("FAIL alarmon_idle: got %0d buzz cycles want 0", n_buzz);
        end
    endtask

    task automatic test_async_reset();
        pulse_tick();
        #3;
        n_cmp++;
        if (Buzz !== 1'b1) begin
            n_err++;
            $display("FAIL prereset_buzz: got %b want 1", Buzz);
        end
        cyc(1);
        #2;
        Reset = 1'b0;
        #1;
        n_cmp++;
        if (Buzz !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_buzz: got %b want 0", Buzz);
        end
        cyc(2);
        Reset = 1'b1;
        clear_counts();
        cyc(4);
        n_cmp++;
        if (n_buzz !== 0) begin
            n_err++;
            $display("FAIL post_reset_quiet: got %0d buzz cycles want 0", n_buzz);
        end
        pulse_tick();
        #3;
        n_cmp++;
        if (Buzz !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_trigger: got %b want 1", Buzz);
        end
        cyc(1);
        Timeset = 1'b1;
        #3;
        n_cmp++;
        if (Buzz !== 1'b1) begin
            n_err++;
            $display("FAIL mode_gate_pre: got %b want 1", Buzz);
        end
        cyc(1);
        #3;
        n_cmp++;
        if (Buzz !== 1'b0) begin
            n_err++;
            $display("FAIL mode_gate: got %b want 0", Buzz);
        end
        Timeset = 1'b0;
        clear_counts();
        cyc(4);
        n_cmp++;
        if (n_buzz !== 0) begin
            n_err++;
            $display("FAIL mode_gate_idle: got %0d buzz cycles want 0", n_buzz);
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_time_set();
        test_mode_priority();
        test_alarm_buzz();
        test_snooze();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Control/sequencing block for the alarm-clock datapath: the seconds/minutes/hours counters, the alarm registers and the buzzer.
- Converts the free-running Pulse tick and the user inputs (Timeset, Alarmset, Minadv, Hrsadv, Alarmon, Snooze) into single-cycle enable/increment strobes.
- Owns the operating mode and the alarm/buzz/snooze state machine.
- Sits between the testbench/top-level inputs and the counter and seven-segment datapath inside struct_diag.

Parameters:
BUZZ_SEC, 60, ticks Buzz stays asserted before auto-silence
SNZ_SEC, 300, ticks of snooze before re-buzz
RPT, 1, ticks between auto-repeat advances while Minadv/Hrsadv held (1..15)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
Pulse  in  1  timebase square wave, asynchronous to Clk; one rising edge = one tick (one second)
Timeset  in  1  level, time-set mode request
Alarmset  in  1  level, alarm-set mode request
Minadv  in  1  level, minute advance button
Hrsadv  in  1  level, hour advance button
Alarmon  in  1  level, alarm enable
Snooze  in  1  level, snooze button
Alarm_match  in  1  from comparator: current time HH:MM == alarm HH:MM
Sec_en  out  1  one-cycle strobe: seconds counter counts
Min_inc  out  1  one-cycle strobe: time minutes +1 (no carry into hours)
Hrs_inc  out  1  one-cycle strobe: time hours +1
Amin_inc  out  1  one-cycle strobe: alarm minutes +1
Ahrs_inc  out  1  one-cycle strobe: alarm hours +1
Disp_alarm  out  1  1 = display shows alarm registers
Buzz  out  1  buzzer drive

Behaviour:
- Reset (Reset=0, asynchronous): all outputs 0; mode=RUN; alarm FSM=IDLE; all tick counters 0; synchronizer flops 0.
- Tick generation:
  - Pulse passes through a 2-flop synchronizer, then a rising-edge detect.
  - tick is high for exactly one Clk cycle, 3 Clk cycles after the Pulse rising edge.
- Button edge detect: Minadv, Hrsadv, Snooze and Alarm_match are each registered once; rise = current & ~previous.
- Mode FSM: RUN, TSET, ASET, re-evaluated every cycle.
  - Timeset=1 -> TSET, else Alarmset=1 -> ASET, else RUN. Timeset wins when both are high.
  - RUN: Sec_en=tick; advance buttons ignored.
  - TSET: Sec_en=0 (time frozen).
    - Advance strobes go to Min_inc/Hrs_inc.
    - Disp_alarm=0.
  - ASET: Sec_en=tick (time keeps running).
    - Advance strobes go to Amin_inc/Ahrs_inc.
    - Disp_alarm=1 (registered, asserted the cycle after entry).
- Advance sequencing, per button, in TSET/ASET only:
  - Button rise -> one strobe that cycle, and the repeat counter loads 0.
  - While held, the counter increments on each tick; when it reaches RPT, one strobe fires and the counter reloads 0.
  - Minadv and Hrsadv are independent and may strobe in the same cycle.
  - Release clears that button's counter.
  - A mode change clears both counters. A button already held on mode entry counts as a rise.
- Alarm FSM: IDLE, BUZZ, SNZ, QUIET; one shared tick counter, 9 bits.
  - IDLE -> BUZZ: mode=RUN & Alarmon & Alarm_match & tick. Counter=0.
  - BUZZ: Buzz=1; counter++ on tick.
    - counter reaches BUZZ_SEC -> QUIET.
    - Snooze rise -> SNZ, counter=0. Snooze rise beats timeout in the same cycle.
  - SNZ: Buzz=0; counter++ on tick; counter reaches SNZ_SEC -> BUZZ, counter=0. Alarm_match is not required.
  - QUIET: Buzz=0; falling edge of Alarm_match -> IDLE. This prevents re-trigger within the matching minute.
  - From any state: Alarmon=0 or mode≠RUN -> IDLE next cycle, Buzz=0 that cycle (combinational gating). This has priority over every other transition.
- Buzz is registered state decoded; asserted the cycle after the trigger tick.
- Simultaneous tick and advance rise: the advance strobe fires once only; the repeat counter starts from 0.
- Reset mid-buzz or mid-snooze: immediate return to IDLE, Buzz=0 asynchronously.

Test Plan:
1. Reset=0 for 5 cycles, with Pulse toggling, then release -> all outputs 0 during reset; first Sec_en exactly 3 Clk after the next Pulse rising edge; one Sec_en per Pulse period.
2. Timeset=1, Minadv held for 50 ticks, RPT=1 -> Sec_en stays 0; Min_inc count = 51 (1 on press + 50 repeats); Amin_inc=0.
3. Alarmset=1 and Timeset=1 together, Hrsadv pulsed once -> mode TSET; exactly 1 Hrs_inc, 0 Ahrs_inc; Disp_alarm=0. Drop Timeset -> Disp_alarm=1 one cycle later.
4. RUN, Alarmon=1, Alarm_match raised, BUZZ_SEC=4 -> Buzz rises 1 cycle after the next tick, stays high 4 ticks, then 0. It stays 0 while match is held and re-arms only after match falls and rises again.
5. Buzzing, Snooze pulse, SNZ_SEC=3 -> Buzz falls the next cycle; Buzz returns after 3 ticks. Then Alarmon=0 -> Buzz=0 the same cycle, FSM IDLE.
6. Buzzing, assert Reset=0 asynchronously between Clk edges -> Buzz=0 without waiting for a clock edge. After release, no Buzz until a new qualifying tick with Alarm_match=1.
